// File: rtl/chip8_mem_arbiter.sv
// N-channel fixed/round-robin arbiter onto one single-port memory; issue 1 cycle after grant, response 2+MEM_LAT cycles after grant.
// One grant per cycle; ungranted clients see ready low and must hold or drop their request (nothing is latched).
module chip8_mem_arbiter #(
  parameter int N_CH    = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TYPE_W  = 2,
  parameter int MEM_LAT = 2,
  parameter int RR_MODE = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [N_CH-1:0]          ch_valid_in,
  input  logic [N_CH-1:0]          ch_we_in,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr_in,
  input  logic [N_CH*DATA_W-1:0]   ch_data_in,
  input  logic [N_CH*TYPE_W-1:0]   ch_type_in,
  output logic [N_CH-1:0]          ch_ready_out,
  output logic [N_CH-1:0]          ch_valid_out,
  output logic [DATA_W-1:0]        ch_data_out,
  output logic                     mem_valid_out,
  output logic                     mem_we_out,
  output logic [ADDR_W-1:0]        mem_addr_out,
  output logic [DATA_W-1:0]        mem_data_out,
  output logic [TYPE_W-1:0]        mem_type_out,
  input  logic [DATA_W-1:0]        mem_data_in
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SCN_W = CH_W + 1;

  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
    logic            we;
  } tag_t;

  logic              running;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   base_idx;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_W-1:0]   issue_ch;
  logic              grant_vld;
  logic              accept;
  logic [SCN_W-1:0]  scan_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [TYPE_W-1:0] sel_type;
  tag_t              tag_pipe [MEM_LAT+1];
  tag_t              tag_tail;

  assign base_idx = (RR_MODE != 0) ? rr_ptr : '0;

  // Scan from the far end back toward base so the channel nearest base wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      scan_idx = {1'b0, base_idx} + SCN_W'(k);
      if (scan_idx >= SCN_W'(N_CH)) scan_idx = scan_idx - SCN_W'(N_CH);
      if (ch_valid_in[scan_idx[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[CH_W-1:0];
      end
    end
  end

  // Grants are held off until the first edge after reset release.
  assign accept = running & grant_vld;

  always_comb begin
    ch_ready_out = '0;
    if (accept) ch_ready_out[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_type = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_idx == CH_W'(i)) begin
        sel_we   = ch_we_in[i];
        sel_addr = ch_addr_in[i*ADDR_W +: ADDR_W];
        sel_data = ch_data_in[i*DATA_W +: DATA_W];
        sel_type = ch_type_in[i*TYPE_W +: TYPE_W];
      end
    end
  end

  assign tag_tail = tag_pipe[MEM_LAT];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      running       <= 1'b0;
      rr_ptr        <= '0;
      issue_ch      <= '0;
      mem_valid_out <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_data_out  <= '0;
      mem_type_out  <= '0;
      ch_valid_out  <= '0;
      ch_data_out   <= '0;
      for (int i = 0; i <= MEM_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      running       <= 1'b1;
      mem_valid_out <= accept;
      if (accept) begin
        issue_ch     <= grant_idx;
        mem_we_out   <= sel_we;
        mem_addr_out <= sel_addr;
        mem_data_out <= sel_data;
        mem_type_out <= sel_type;
        rr_ptr       <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
      // Tag enters the pipe one edge after issue, in step with the memory seeing the request.
      tag_pipe[0] <= {mem_valid_out, issue_ch, mem_we_out};
      for (int i = 1; i <= MEM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      ch_valid_out <= '0;
      if (tag_tail.vld) begin
        ch_valid_out[tag_tail.ch] <= 1'b1;
        ch_data_out               <= tag_tail.we ? '0 : mem_data_in;
      end
    end
  end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: four instances (RR lat2, fixed lat2, RR lat1, RR lat4) driven by shared stimulus,
// each with its own memory and a transaction-level reference model.
module tb_chip8_mem_arbiter;

  localparam int NI = 4;

  function automatic int lat_of(input int i);
    case (i)
      2:       return 1;
      3:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic bit rr_of(input int i);
    return (i != 1);
  endfunction

  function automatic logic [7:0] init_val(input logic [11:0] a);
    return (a == 12'h200) ? 8'hA2 : (a[7:0] ^ 8'h3C);
  endfunction

  logic        clk;
  logic        rst_n;
  logic [2:0]  ch_valid;
  logic [2:0]  ch_we;
  logic [35:0] ch_addr;
  logic [23:0] ch_data;
  logic [5:0]  ch_type;

  logic [2:0]  o_ready [NI];
  logic [2:0]  o_cvld  [NI];
  logic [7:0]  o_cdat  [NI];
  logic        o_mvld  [NI];
  logic        o_mwe   [NI];
  logic [11:0] o_maddr [NI];
  logic [7:0]  o_mdat  [NI];
  logic [1:0]  o_mtype [NI];
  logic [7:0]  m_din   [NI];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int L  = lat_of(gi);
    localparam int RR = rr_of(gi) ? 1 : 0;
    logic [7:0] ram     [4096];
    logic [7:0] rd_pipe [5];

    chip8_mem_arbiter #(
      .N_CH(3), .ADDR_W(12), .DATA_W(8), .TYPE_W(2), .MEM_LAT(L), .RR_MODE(RR)
    ) u_dut (
      .clk_in(clk), .rst_in(rst_n),
      .ch_valid_in(ch_valid), .ch_we_in(ch_we), .ch_addr_in(ch_addr),
      .ch_data_in(ch_data), .ch_type_in(ch_type),
      .ch_ready_out(o_ready[gi]), .ch_valid_out(o_cvld[gi]), .ch_data_out(o_cdat[gi]),
      .mem_valid_out(o_mvld[gi]), .mem_we_out(o_mwe[gi]), .mem_addr_out(o_maddr[gi]),
      .mem_data_out(o_mdat[gi]), .mem_type_out(o_mtype[gi]), .mem_data_in(m_din[gi])
    );

    initial begin
      for (int a = 0; a < 4096; a++) ram[a] <= init_val(12'(a));
      for (int k = 0; k < 5; k++) rd_pipe[k] <= 8'h00;
    end

    // Memory latches the request one edge after issue; data appears L edges later.
    always @(posedge clk) begin
      if (o_mvld[gi]) begin
        if (o_mwe[gi]) ram[o_maddr[gi]] <= o_mdat[gi];
        rd_pipe[0] <= o_mwe[gi] ? 8'hEE : ram[o_maddr[gi]];
      end else begin
        rd_pipe[0] <= 8'hEE;
      end
      for (int k = 1; k < 5; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    assign m_din[gi] = rd_pipe[L];
  end

  // Reference model state, one copy per instance.
  int          m_ptr   [NI];
  bit          m_run   [NI];
  int          m_win   [NI];
  bit          m_mvld  [NI];
  bit          m_mwe   [NI];
  logic [11:0] m_maddr [NI];
  logic [7:0]  m_mdat  [NI];
  logic [1:0]  m_mtype [NI];
  bit          rv      [NI][8];
  int          rch     [NI][8];
  logic [7:0]  rdat    [NI][8];
  logic [7:0]  mmem    [NI][4096];

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", nm, inst, cyc, act, exp);
    end
  endtask

  task automatic model_check(input int i);
    int s;
    int idx;
    logic [2:0] exp_rdy;
    logic [2:0] exp_cv;
    if (!rst_n) begin
      m_run[i] = 0;
      m_ptr[i] = 0;
      m_mvld[i] = 0;
      for (int k = 0; k < 8; k++) rv[i][k] = 0;
      chk("rst_maddr", i, 32'(o_maddr[i]), 0);
      chk("rst_mdat", i, 32'(o_mdat[i]), 0);
      chk("rst_mwe", i, 32'(o_mwe[i]), 0);
      chk("rst_mtype", i, 32'(o_mtype[i]), 0);
      chk("rst_cdat", i, 32'(o_cdat[i]), 0);
    end
    m_win[i] = -1;
    if (m_run[i] && rst_n) begin
      for (int k = 2; k >= 0; k--) begin
        idx = ((rr_of(i) ? m_ptr[i] : 0) + k) % 3;
        if (ch_valid[idx]) m_win[i] = idx;
      end
    end
    exp_rdy = (m_win[i] >= 0) ? (3'b001 << m_win[i]) : 3'b000;
    chk("ready", i, 32'(o_ready[i]), 32'(exp_rdy));
    chk("mem_valid", i, 32'(o_mvld[i]), 32'(m_mvld[i]));
    if (m_mvld[i]) begin
      chk("mem_we", i, 32'(o_mwe[i]), 32'(m_mwe[i]));
      chk("mem_addr", i, 32'(o_maddr[i]), 32'(m_maddr[i]));
      chk("mem_type", i, 32'(o_mtype[i]), 32'(m_mtype[i]));
      if (m_mwe[i]) chk("mem_wdata", i, 32'(o_mdat[i]), 32'(m_mdat[i]));
    end
    s = cyc % 8;
    exp_cv = rv[i][s] ? (3'b001 << rch[i][s]) : 3'b000;
    chk("resp_valid", i, 32'(o_cvld[i]), 32'(exp_cv));
    if (rv[i][s]) chk("resp_data", i, 32'(o_cdat[i]), 32'(rdat[i][s]));
    rv[i][s] = 0;
  endtask

  task automatic model_step(input int i);
    int w;
    int due;
    logic [11:0] a;
    logic [7:0]  rd;
    if (!rst_n) return;
    m_run[i]  = 1;
    w         = m_win[i];
    m_mvld[i] = (w >= 0);
    if (w >= 0) begin
      a = ch_addr[w*12 +: 12];
      m_mwe[i]   = ch_we[w];
      m_maddr[i] = a;
      m_mdat[i]  = ch_data[w*8 +: 8];
      m_mtype[i] = ch_type[w*2 +: 2];
      if (ch_we[w]) begin
        mmem[i][a] = ch_data[w*8 +: 8];
        rd = 8'h00;
      end else begin
        rd = mmem[i][a];
      end
      due = (cyc + 1 + lat_of(i) + 2) % 8;
      rv[i][due]   = 1;
      rch[i][due]  = w;
      rdat[i][due] = rd;
      m_ptr[i] = (w + 1) % 3;
    end
  endtask

  task automatic cycle();
    #1;
    for (int i = 0; i < NI; i++) model_check(i);
    for (int i = 0; i < NI; i++) model_step(i);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    ch_valid = 3'b000;
    ch_we    = 3'b000;
    for (int k = 0; k < n; k++) cycle();
  endtask

  typedef struct {
    logic [2:0] valid;
    logic [2:0] exp_rr;
    logic [2:0] exp_fix;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{3'b111, 3'b001, 3'b001};
    tbl[1]  = '{3'b111, 3'b010, 3'b001};
    tbl[2]  = '{3'b111, 3'b100, 3'b001};
    tbl[3]  = '{3'b111, 3'b001, 3'b001};
    tbl[4]  = '{3'b111, 3'b010, 3'b001};
    tbl[5]  = '{3'b111, 3'b100, 3'b001};
    tbl[6]  = '{3'b000, 3'b000, 3'b000};
    tbl[7]  = '{3'b110, 3'b010, 3'b010};
    tbl[8]  = '{3'b011, 3'b001, 3'b001};
    tbl[9]  = '{3'b101, 3'b100, 3'b001};
    tbl[10] = '{3'b100, 3'b100, 3'b100};
    tbl[11] = '{3'b000, 3'b000, 3'b000};

    for (int i = 0; i < NI; i++)
      for (int a = 0; a < 4096; a++) mmem[i][a] = init_val(12'(a));

    rst_n = 1'b0;
    ch_valid = '0; ch_we = '0; ch_addr = '0; ch_data = '0; ch_type = '0;
    @(negedge clk);
    cycle();
    cycle();
    rst_n = 1'b1;
    idle(1);

    // Grant pattern table: six-cycle fairness run, then mixed requests.
    for (int r = 0; r < 12; r++) begin
      ch_valid = tbl[r].valid;
      ch_we    = 3'b000;
      for (int c = 0; c < 3; c++) begin
        ch_addr[c*12 +: 12] = 12'h100 + 12'(r*4 + c);
        ch_type[c*2 +: 2]   = 2'(r + c);
      end
      #1;
      chk("tbl_rr_l2", 0, 32'(o_ready[0]), 32'(tbl[r].exp_rr));
      chk("tbl_fixed", 1, 32'(o_ready[1]), 32'(tbl[r].exp_fix));
      chk("tbl_rr_l1", 2, 32'(o_ready[2]), 32'(tbl[r].exp_rr));
      chk("tbl_rr_l4", 3, 32'(o_ready[3]), 32'(tbl[r].exp_rr));
      cycle();
    end
    idle(8);

    // Single read of 0x200 on ch0.
    ch_addr[11:0] = 12'h200;
    ch_type[1:0]  = 2'b10;
    ch_we         = 3'b000;
    ch_valid      = 3'b001;
    cycle();
    ch_valid = 3'b000;
    chk("rd_issue_vld", 0, 32'(o_mvld[0]), 1);
    chk("rd_issue_addr", 0, 32'(o_maddr[0]), 32'h200);
    chk("rd_issue_type", 0, 32'(o_mtype[0]), 2);
    cycle(); cycle(); cycle();
    chk("rd_not_early", 0, 32'(o_cvld[0]), 0);
    cycle();
    chk("rd_resp_vld", 0, 32'(o_cvld[0]), 32'b001);
    chk("rd_resp_data", 0, 32'(o_cdat[0]), 32'hA2);
    idle(6);

    // Write ack on ch2, then read back on ch0.
    ch_addr[35:24] = 12'h050;
    ch_data[23:16] = 8'h55;
    ch_we          = 3'b100;
    ch_valid       = 3'b100;
    cycle();
    ch_valid = 3'b000;
    ch_we    = 3'b000;
    chk("wr_issue_we", 0, 32'(o_mwe[0]), 1);
    chk("wr_issue_data", 0, 32'(o_mdat[0]), 32'h55);
    chk("wr_issue_addr", 0, 32'(o_maddr[0]), 32'h050);
    for (int k = 0; k < 4; k++) cycle();
    chk("wr_ack_vld", 0, 32'(o_cvld[0]), 32'b100);
    chk("wr_ack_data", 0, 32'(o_cdat[0]), 0);
    ch_addr[11:0] = 12'h050;
    ch_valid      = 3'b001;
    cycle();
    ch_valid = 3'b000;
    for (int k = 0; k < 4; k++) cycle();
    chk("rdback_vld", 0, 32'(o_cvld[0]), 32'b001);
    chk("rdback_data", 0, 32'(o_cdat[0]), 32'h55);
    idle(6);

    // Reset while a ch1 read is in flight.
    ch_addr[23:12] = 12'h200;
    ch_valid       = 3'b010;
    cycle();
    idle(2);
    rst_n = 1'b0;
    #1;
    chk("rst_async_mvld", 0, 32'(o_mvld[0]), 0);
    chk("rst_async_cvld", 0, 32'(o_cvld[0]), 0);
    cycle();
    cycle();
    rst_n    = 1'b1;
    ch_valid = 3'b111;
    #1;
    chk("rel_gated", 0, 32'(o_ready[0]), 0);
    cycle();
    #1;
    chk("rel_ptr0", 0, 32'(o_ready[0]), 32'b001);
    cycle();
    ch_valid = 3'b000;
    for (int k = 0; k < 8; k++) begin
      chk("no_stale_ch1", 0, 32'(o_cvld[0][1]), 0);
      cycle();
    end

    // Randomised traffic with read-after-write on a small address window.
    for (int k = 0; k < 400; k++) begin
      ch_valid = 3'($urandom_range(0, 7));
      ch_we    = 3'($urandom_range(0, 7));
      for (int c = 0; c < 3; c++) begin
        ch_addr[c*12 +: 12] = 12'h300 + 12'($urandom_range(0, 7));
        ch_data[c*8 +: 8]   = 8'($urandom);
        ch_type[c*2 +: 2]   = 2'($urandom);
      end
      cycle();
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/chip8_mem_arbiter.md
Name: chip8_mem_arbiter

Overview:
- Parametrised N-channel request arbiter placed between CHIP-8 memory clients (processor, video, debug, future DMA) and a single-port synchronous memory with configurable read latency.
- Accepts at most one request per cycle.
- Tags every accepted request and routes the memory response back to the issuing channel after a fixed latency.
- Generalises the fixed proc/video/debug ports into N uniform channels, with selectable fixed-priority or round-robin arbitration.

Parameters:
- N_CH, 3, number of client channels (2..8); channel 0 has the highest fixed priority.
- ADDR_W, 12, address width per channel.
- DATA_W, 8, data width.
- TYPE_W, 2, access-type field width; passed through to memory unchanged.
- MEM_LAT, 2, memory read latency in cycles from mem_valid_out to memory data valid (1..4).
- RR_MODE, 1, arbitration mode: 1 = round-robin, 0 = fixed priority.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- ch_valid_in  input  N_CH  per-channel request valid
- ch_we_in  input  N_CH  per-channel write enable
- ch_addr_in  input  N_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W]
- ch_data_in  input  N_CH*DATA_W  per-channel write data
- ch_type_in  input  N_CH*TYPE_W  per-channel access type
- ch_ready_out  output  N_CH  one-hot grant; request accepted when valid & ready
- ch_valid_out  output  N_CH  one-hot response valid (read data or write ack)
- ch_data_out  output  DATA_W  response data, shared by all channels
- mem_valid_out  output  1  memory request strobe
- mem_we_out  output  1  memory write enable
- mem_addr_out  output  ADDR_W  memory address
- mem_data_out  output  DATA_W  memory write data
- mem_type_out  output  TYPE_W  memory access type
- mem_data_in  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_valid_out

Behaviour:
- Reset (rst_in low, asynchronous):
  - All outputs 0; round-robin pointer = 0.
  - Tag pipeline cleared; in-flight responses are dropped and never delivered.
  - Outputs stay 0 through the first cycle after release.
- Grant (combinational on ch_valid_in and the pointer):
  - At most one ch_ready_out bit set per cycle; no bit set when ch_valid_in == 0.
  - Fixed mode: lowest-index valid channel wins.
  - RR mode: search starts at the pointer index and wraps modulo N_CH; first valid channel wins.
  - After a grant to channel g, pointer <= (g+1) mod N_CH. Pointer holds on idle cycles.
- Issue:
  - On the clock edge of acceptance, mem_valid_out, mem_we_out, mem_addr_out, mem_data_out and mem_type_out are registered from the granted channel.
  - mem_valid_out is high for exactly one cycle per accepted request. Back-to-back issue every cycle is allowed.
- Tag pipeline:
  - Shift register of depth MEM_LAT+1 holding {valid, channel index, we}.
  - Advances every cycle; a new entry is inserted on acceptance.
- Response:
  - Exactly 1+MEM_LAT+1 cycles after acceptance (acceptance edge T → ch_valid_out at T+MEM_LAT+2), ch_valid_out[g] pulses for one cycle.
  - ch_data_out = registered mem_data_in for reads, 0 for writes.
  - Responses are delivered in acceptance order. One response per cycle maximum, so no collision is possible.
- ch_data_out holds its last value when no response is valid; the bench may check it only while ch_valid_out is non-zero.
- Client that deasserts valid without being granted: the request is simply not issued. No latching of ungranted requests.
- Same channel holding valid across consecutive cycles: each granted cycle is a distinct request.
- Simultaneous acceptance and response delivery in the same cycle is independent; both proceed.
- Channel index encoding uses $clog2(N_CH) bits, minimum 1.

Test Plan:
- Reset mid-flight (N_CH=3, MEM_LAT=2): issue read ch1 addr 0x200, assert rst_in low 2 cycles later, release → no ch_valid_out pulse ever; all outputs 0 during reset; pointer = 0.
- Single read: ch0 reads 0x200 with memory model returning 0xA2 → mem_valid_out one cycle after accept with addr 0x200, type passed through; ch_valid_out = 3'b001 and ch_data_out = 0xA2 at accept+4.
- RR fairness: all three channels hold valid for 6 cycles → grant sequence 0,1,2,0,1,2; responses return in that order with matching data.
- Fixed priority (RR_MODE=0): same stimulus → ch0 granted all 6 cycles; ch1 and ch2 never see ready.
- Write ack: ch2 writes 0x55 to 0x050 → mem_we_out=1 and mem_data_out=0x55; ch_valid_out = 3'b100 with ch_data_out = 0 at accept+4; subsequent ch0 read of 0x050 returns 0x55.
- Latency sweep: MEM_LAT=1 and 4 with back-to-back reads of 8 addresses → every response arrives at accept+MEM_LAT+2 on the correct channel, none dropped or duplicated.
